// File: rtl/rx_deframer.sv
// rx_deframer: strips training/header/trailer framing from an aligned word
// stream, forwards payload words with sof/eof marks and checks a 16-bit XOR
// checksum carried in the trailer.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   aligned, idata      - upstream alignment flag and word ([0:W-1], bit 0 MSB)
//   odata, ovalid       - payload word and its valid flag (1-cycle latency)
//   osof, oeof          - first / last payload word of a frame
//   ogood, obad         - frame completion pulses (good / failed or aborted)
//   err_count           - saturating count of bad frames and illegal idle words
module rx_deframer #(
    parameter int W = 128
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         aligned,
    input  logic [0:W-1] idata,
    output logic [0:W-1] odata,
    output logic         ovalid,
    output logic         osof,
    output logic         oeof,
    output logic         ogood,
    output logic         obad,
    output logic [15:0]  err_count
);

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        HUNT    = 2'd1,
        PAYLOAD = 2'd2,
        TRAILER = 2'd3
    } state_t;

    localparam logic [0:W-1] TRAIN_5 = {(W/4){4'h5}};
    localparam logic [0:W-1] TRAIN_A = {(W/4){4'hA}};

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   len_q, len_d;
    logic [15:0]  csum_q, csum_d;
    logic [0:W-1] odata_q, odata_d;
    logic         ovalid_q, ovalid_d;
    logic         osof_q, osof_d;
    logic         oeof_q, oeof_d;
    logic         ogood_q, ogood_d;
    logic         obad_q, obad_d;
    logic [15:0]  err_q, err_d;

    logic         is_train;
    logic         is_hdr;
    logic         is_trl;
    logic         err_inc;
    logic [15:0]  fold;

    // XOR of every 16-bit lane of the incoming word
    always_comb begin
        fold = '0;
        for (int k = 0; k < W / 16; k++) begin
            fold = fold ^ idata[16*k +: 16];
        end
    end

    assign is_train = (idata == TRAIN_5) || (idata == TRAIN_A);
    assign is_hdr   = (idata[0:15] == 16'hFB5D);
    assign is_trl   = (idata[0:15] == 16'hFD7E);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        csum_d   = csum_q;
        odata_d  = odata_q;
        ovalid_d = 1'b0;
        osof_d   = 1'b0;
        oeof_d   = 1'b0;
        ogood_d  = 1'b0;
        obad_d   = 1'b0;
        err_inc  = 1'b0;

        if (!aligned) begin
            // Losing alignment mid-frame aborts it; idata is discarded.
            state_d = WAIT;
            if (state_q == PAYLOAD || state_q == TRAILER) begin
                obad_d  = 1'b1;
                err_inc = 1'b1;
            end
        end else begin
            unique case (state_q)
                WAIT: begin
                    state_d = HUNT;
                end
                HUNT: begin
                    if (is_train) begin
                        state_d = HUNT;
                    end else if (is_hdr) begin
                        if (idata[16:23] != 8'd0) begin
                            len_d   = idata[16:23];
                            cnt_d   = 8'd0;
                            csum_d  = 16'd0;
                            state_d = PAYLOAD;
                        end else begin
                            obad_d  = 1'b1;
                            err_inc = 1'b1;
                        end
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                PAYLOAD: begin
                    odata_d  = idata;
                    ovalid_d = 1'b1;
                    osof_d   = (cnt_q == 8'd0);
                    csum_d   = csum_q ^ fold;
                    cnt_d    = cnt_q + 8'd1;
                    if (cnt_d == len_q) begin
                        oeof_d  = 1'b1;
                        state_d = TRAILER;
                    end
                end
                TRAILER: begin
                    if (is_trl && idata[16:31] == csum_q) begin
                        ogood_d = 1'b1;
                    end else begin
                        obad_d  = 1'b1;
                        err_inc = 1'b1;
                    end
                    state_d = HUNT;
                end
                default: state_d = WAIT;
            endcase
        end

        err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= WAIT;
            cnt_q    <= '0;
            len_q    <= '0;
            csum_q   <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            osof_q   <= 1'b0;
            oeof_q   <= 1'b0;
            ogood_q  <= 1'b0;
            obad_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            csum_q   <= csum_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            osof_q   <= osof_d;
            oeof_q   <= oeof_d;
            ogood_q  <= ogood_d;
            obad_q   <= obad_d;
            err_q    <= err_d;
        end
    end

    assign odata     = odata_q;
    assign ovalid    = ovalid_q;
    assign osof      = osof_q;
    assign oeof      = oeof_q;
    assign ogood     = ogood_q;
    assign obad      = obad_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_rx_deframer.sv
// tb_rx_deframer: directed stimulus for rx_deframer, W = 128.
// Each step drives one word, waits one edge, then checks the registered outputs.
module tb_rx_deframer;

    localparam int W = 128;

    logic         clock = 1'b0;
    logic         reset;
    logic         aligned;
    logic [0:W-1] idata;
    logic [0:W-1] odata;
    logic         ovalid;
    logic         osof;
    logic         oeof;
    logic         ogood;
    logic         obad;
    logic [15:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    rx_deframer #(.W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .aligned   (aligned),
        .idata     (idata),
        .odata     (odata),
        .ovalid    (ovalid),
        .osof      (osof),
        .oeof      (oeof),
        .ogood     (ogood),
        .obad      (obad),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    function automatic logic [0:W-1] hdr(input logic [7:0] l);
        return {16'hFB5D, l, 104'h0};
    endfunction

    function automatic logic [0:W-1] trl(input logic [15:0] c);
        return {16'hFD7E, c, 96'h0};
    endfunction

    function automatic logic [15:0] fold(input logic [127:0] d);
        logic [15:0] f;
        logic [127:0] t;
        f = '0;
        t = d;
        for (int k = 0; k < 8; k++) begin
            f = f ^ t[15:0];
            t = t >> 16;
        end
        return f;
    endfunction

    task automatic step(input logic a, input logic [0:W-1] d);
        aligned = a;
        idata   = d;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic v, input logic s,
                             input logic e, input logic g, input logic b);
        chk({tag, ".ovalid"}, 128'(ovalid), 128'(v));
        chk({tag, ".osof"},   128'(osof),   128'(s));
        chk({tag, ".oeof"},   128'(oeof),   128'(e));
        chk({tag, ".ogood"},  128'(ogood),  128'(g));
        chk({tag, ".obad"},   128'(obad),   128'(b));
    endtask

    logic [0:W-1] tr5, tra, zero, p0, p1, p2, q0, r0, r1;
    logic [15:0]  c;

    initial begin
        tr5  = {32{4'h5}};
        tra  = {32{4'hA}};
        zero = '0;
        p0   = 128'h0123_4567_89AB_CDEF_1122_3344_5566_7788;
        p1   = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1357_9BDF;
        p2   = 128'hFFFF_0000_A5A5_5A5A_1234_8765_0F0F_F0F0;
        q0   = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        r0   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        r1   = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

        // reset state
        reset = 1'b1;
        aligned = 1'b1;
        idata = tr5;
        step(1'b1, p0);
        chk_flags("reset", 0, 0, 0, 0, 0);
        chk("reset.odata", 128'(odata), 128'h0);
        chk("reset.err", 128'(err_count), 128'h0);
        reset = 1'b0;

        // good frame, L = 3
        step(1'b1, hdr(8'd3));
        step(1'b1, tr5);
        step(1'b1, tra);
        chk("train.err", 128'(err_count), 128'h0);
        step(1'b1, hdr(8'd3));
        chk_flags("good.hdr", 0, 0, 0, 0, 0);
        step(1'b1, p0);
        chk_flags("good.p0", 1, 1, 0, 0, 0);
        chk("good.p0.data", 128'(odata), 128'(p0));
        step(1'b1, p1);
        chk_flags("good.p1", 1, 0, 0, 0, 0);
        chk("good.p1.data", 128'(odata), 128'(p1));
        step(1'b1, p2);
        chk_flags("good.p2", 1, 0, 1, 0, 0);
        chk("good.p2.data", 128'(odata), 128'(p2));
        c = fold(p0 ^ p1 ^ p2);
        step(1'b1, trl(c));
        chk_flags("good.trl", 0, 0, 0, 1, 0);
        chk("good.hold", 128'(odata), 128'(p2));
        step(1'b1, tr5);
        chk_flags("good.after", 0, 0, 0, 0, 0);
        chk("good.err", 128'(err_count), 128'h0);

        // bad checksum
        step(1'b1, hdr(8'd3));
        step(1'b1, p0);
        step(1'b1, p1);
        step(1'b1, p2);
        step(1'b1, trl(c ^ 16'h0001));
        chk_flags("badc.trl", 0, 0, 0, 0, 1);
        chk("badc.err", 128'(err_count), 128'h1);

        // one-word frame
        step(1'b1, hdr(8'd1));
        step(1'b1, q0);
        chk_flags("one.q0", 1, 1, 1, 0, 0);
        chk("one.q0.data", 128'(odata), 128'(q0));
        step(1'b1, trl(fold(q0)));
        chk_flags("one.trl", 0, 0, 0, 1, 0);

        // header inside payload is data, L = 2
        step(1'b1, hdr(8'd2));
        step(1'b1, hdr(8'd7));
        chk_flags("hdrdata.w0", 1, 1, 0, 0, 0);
        chk("hdrdata.w0.data", 128'(odata), 128'(hdr(8'd7)));
        step(1'b1, r0);
        chk_flags("hdrdata.w1", 1, 0, 1, 0, 0);
        step(1'b1, trl(fold(hdr(8'd7) ^ r0)));
        chk_flags("hdrdata.trl", 0, 0, 0, 1, 0);
        chk("hdrdata.err", 128'(err_count), 128'h1);

        // abort after 2 of 5 payloads
        step(1'b1, hdr(8'd5));
        step(1'b1, r0);
        step(1'b1, r1);
        chk_flags("abort.r1", 1, 0, 0, 0, 0);
        step(1'b0, p0);
        chk_flags("abort.drop", 0, 0, 0, 0, 1);
        chk("abort.err", 128'(err_count), 128'h2);
        step(1'b0, hdr(8'd1));
        chk_flags("abort.wait0", 0, 0, 0, 0, 0);
        step(1'b1, hdr(8'd1));
        chk_flags("abort.wait1", 0, 0, 0, 0, 0);
        step(1'b1, tr5);
        chk_flags("abort.hunt", 0, 0, 0, 0, 0);
        chk("abort.err2", 128'(err_count), 128'h2);

        // illegal idle words from a clean start
        reset = 1'b1;
        step(1'b1, tr5);
        reset = 1'b0;
        step(1'b1, tr5);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, zero);
            chk_flags("idle.zero", 0, 0, 0, 0, 0);
        end
        step(1'b1, hdr(8'd0));
        chk_flags("idle.l0", 0, 0, 0, 0, 1);
        chk("idle.err", 128'(err_count), 128'h4);

        // saturation
        for (int i = 0; i < 65530; i++) begin
            aligned = 1'b1;
            idata = zero;
            @(posedge clock);
        end
        #1;
        chk("sat.pre", 128'(err_count), 128'hFFFE);
        step(1'b1, zero);
        chk("sat.1", 128'(err_count), 128'hFFFF);
        step(1'b1, hdr(8'd0));
        chk("sat.2", 128'(err_count), 128'hFFFF);
        step(1'b1, zero);
        chk("sat.3", 128'(err_count), 128'hFFFF);

        // mid-frame reset: everything clears, no obad
        step(1'b1, hdr(8'd2));
        step(1'b1, p0);
        reset = 1'b1;
        step(1'b1, p1);
        reset = 1'b0;
        chk_flags("rst", 0, 0, 0, 0, 0);
        chk("rst.odata", 128'(odata), 128'h0);
        chk("rst.err", 128'(err_count), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
